// File: rtl/frame_dumper.sv
// Reads a block of 32-bit words from SDRAM and streams them LSB-first over the
// AVR tx byte interface as: sync byte, data bytes, 8-bit additive checksum.
module frame_dumper #(
  parameter int          ADDR_W    = 23,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  CMD_BYTE  = 8'h44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [31:0]       data_in,
  output logic              in_valid,
  input  logic              busy,
  input  logic [31:0]       data_out,
  input  logic              out_valid,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              active,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TXW,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_BYTE,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    in_valid    = 1'b0;
    new_tx_data = 1'b0;
    tx_data     = 8'h00;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start || (new_rx_data && (rx_data == CMD_BYTE))) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          csum_d      = 8'h00;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        tx_data = SYNC_BYTE;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          ret_d       = (remaining_q != '0) ? S_RD_REQ : S_CSUM;
          state_d     = S_TXW;
        end
      end
      // The transmitter raises tx_busy one cycle late, so skip one cycle
      // before trusting it again.
      S_TXW: begin
        state_d = ret_q;
      end
      S_RD_REQ: begin
        if (!busy) begin
          in_valid = 1'b1;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (out_valid) begin
          shift_d     = data_out;
          byte_idx_d  = 2'd0;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          state_d     = S_TX_BYTE;
        end
      end
      S_TX_BYTE: begin
        tx_data = shift_q[7:0];
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          csum_d      = csum_q + shift_q[7:0];
          shift_d     = shift_q >> 8;
          byte_idx_d  = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            ret_d = (remaining_q != '0) ? S_RD_REQ : S_CSUM;
          end else begin
            ret_d = S_TX_BYTE;
          end
          state_d = S_TXW;
        end
      end
      S_CSUM: begin
        tx_data = csum_q;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          ret_d       = S_DONE;
          state_d     = S_TXW;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr    = addr_q;
  assign rw      = 1'b0;
  assign data_in = 32'h0000_0000;
  assign active  = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_frame_dumper.sv
// Bench for frame_dumper: SDRAM and AVR-tx models, expected byte stream built
// from the memory contents with plain arithmetic.
module tb_frame_dumper;
  localparam int         AW  = 23;
  localparam logic [7:0] CMD = 8'h44;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [7:0]    rx_data = 8'h00;
  logic          new_rx_data = 1'b0;
  logic [AW-1:0] addr;
  logic          rw;
  logic [31:0]   data_in;
  logic          in_valid;
  logic          busy = 1'b0;
  logic [31:0]   data_out = '0;
  logic          out_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy = 1'b0;
  logic          active;
  logic          done;

  frame_dumper #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
    .busy(busy), .data_out(data_out), .out_valid(out_valid),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .active(active), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem [int];
  function automatic logic [31:0] rd(input int a);
    if (mem.exists(a)) return mem[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Monitor: sample DUT outputs on the falling edge
  logic [7:0]    got_bytes [$];
  logic [AW-1:0] got_addrs [$];
  int            done_cnt = 0;
  int            viol_tx = 0;
  int            viol_req = 0;
  bit            strobe_seen = 0;
  bit            req_seen = 0;
  logic [AW-1:0] req_addr = '0;

  always @(negedge clk) begin
    strobe_seen = 0;
    req_seen    = 0;
    if (!rst) begin
      if (new_tx_data) begin
        if (tx_busy !== 1'b0) viol_tx++;
        got_bytes.push_back(tx_data);
        strobe_seen = 1;
      end
      if (in_valid) begin
        if (busy !== 1'b0 || rw !== 1'b0 || data_in !== 32'h0) viol_req++;
        got_addrs.push_back(addr);
        req_addr = addr;
        req_seen = 1;
      end
      if (done) done_cnt++;
    end
  end

  // Peripheral models: drive inputs 1 time unit after the rising edge
  bit tx_stress = 0;
  bit sd_stress = 0;
  int inject_req = 0;
  int inject_done = 0;
  bit tx_arm = 0;
  int tx_cnt = 0;
  int sd_cnt = 0;
  int cyc = 0;
  logic [31:0] sd_data = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    out_valid = 1'b0;
    if (tx_arm) begin
      tx_arm  = 0;
      tx_cnt  = tx_stress ? 50 : int'($urandom_range(0, 3));
      tx_busy = (tx_cnt > 0);
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      tx_busy = (tx_cnt > 0);
    end
    if (strobe_seen) tx_arm = 1;
    if (sd_cnt > 0) begin
      sd_cnt--;
      if (sd_cnt == 0) begin
        out_valid = 1'b1;
        data_out  = sd_data;
      end
    end
    if (req_seen) begin
      sd_cnt  = int'($urandom_range(1, 4));
      sd_data = rd(int'(req_addr));
    end
    if (inject_req != inject_done) begin
      inject_done = inject_req;
      out_valid   = 1'b1;
      data_out    = 32'hDEAD_BEEF;
    end
    busy = (sd_cnt > 0) || (sd_stress && ((cyc % 16) < 10));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_dump(input string tag, input logic [AW-1:0] base,
                          input logic [AW-1:0] cnt, input bit via_rx, input bit mid_start);
    int b0 = got_bytes.size();
    int a0 = got_addrs.size();
    int d0 = done_cnt;
    int t = 0;
    int limit = 2000 + int'(cnt) * 400;
    logic [7:0]    exp [$];
    logic [AW-1:0] ea [$];
    logic [7:0]    s = 8'h00;
    exp.push_back(8'hA5);
    for (int i = 0; i < int'(cnt); i++) begin
      logic [AW-1:0] a = base + AW'(i);
      logic [31:0]   w = rd(int'(a));
      ea.push_back(a);
      for (int k = 0; k < 4; k++) begin
        exp.push_back(w[8*k +: 8]);
        s = s + w[8*k +: 8];
      end
    end
    exp.push_back(s);

    base_addr  = base;
    word_count = cnt;
    if (via_rx) begin
      rx_data     = CMD;
      new_rx_data = 1'b1;
    end else begin
      start = 1'b1;
    end
    @(negedge clk);
    start       = 1'b0;
    new_rx_data = 1'b0;
    base_addr   = ~base;
    word_count  = AW'(5);
    chk({tag, "_active"}, 32'(active), 32'd1);
    while (done_cnt == d0 && t < limit) begin
      @(negedge clk);
      t++;
      start = (mid_start && t == 100);
    end
    start = 1'b0;
    chk({tag, "_no_timeout"}, 32'(t < limit), 32'd1);
    tick(2);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_active_after"}, 32'(active), 32'd0);
    chk({tag, "_byte_count"}, 32'(got_bytes.size() - b0), 32'(exp.size()));
    for (int i = 0; i < exp.size() && b0 + i < got_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[b0 + i]), 32'(exp[i]));
    chk({tag, "_req_count"}, 32'(got_addrs.size() - a0), 32'(ea.size()));
    for (int i = 0; i < ea.size() && a0 + i < got_addrs.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 32'(got_addrs[a0 + i]), 32'(ea[i]));
    $display("dump %s base=%h count=%0d bytes=%0d cycles=%0d", tag, base, cnt, exp.size(), t);
  endtask

  initial begin
    int b0;
    int t;
    tick(3);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_new_tx_data", 32'(new_tx_data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_addr", 32'(addr), 32'd0);
    chk("idle_rw", 32'(rw), 32'd0);
    chk("idle_data_in", data_in, 32'd0);
    chk("idle_in_valid", 32'(in_valid), 32'd0);
    chk("idle_tx_data", 32'(tx_data), 32'd0);
    chk("idle_new_tx_data", 32'(new_tx_data), 32'd0);
    chk("idle_active", 32'(active), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    mem[32'h10] = 32'h4433_2211;
    mem[32'h11] = 32'hDDCC_BBAA;
    run_dump("plan1", AW'(32'h10), AW'(2), 0, 0);
    chk("plan1_csum_literal", 32'(got_bytes[got_bytes.size() - 1]), 32'hB8);

    // Non-command byte and a stray read strobe while idle must do nothing
    b0 = got_bytes.size();
    rx_data = 8'h45;
    new_rx_data = 1'b1;
    inject_req++;
    tick(1);
    new_rx_data = 1'b0;
    tick(4);
    chk("rx45_no_active", 32'(active), 32'd0);
    chk("rx45_no_bytes", 32'(got_bytes.size() - b0), 32'd0);

    mem[0] = 32'h0000_00FF;
    run_dump("rx_cmd", AW'(0), AW'(1), 1, 0);
    chk("rx_cmd_csum_literal", 32'(got_bytes[got_bytes.size() - 1]), 32'hFF);

    run_dump("count0", AW'(32'h123), AW'(0), 0, 0);
    run_dump("wrap", AW'(32'h7FFFFF), AW'(2), 0, 0);

    for (int r = 0; r < 3; r++) begin
      logic [AW-1:0] bb = AW'($urandom);
      logic [AW-1:0] cc = AW'($urandom_range(1, 3));
      for (int i = 0; i < int'(cc); i++) mem[int'(bb + AW'(i))] = $urandom;
      run_dump($sformatf("rand%0d", r), bb, cc, r[0], 0);
    end

    tx_stress = 1;
    sd_stress = 1;
    run_dump("stress", AW'(32'h40), AW'(2), 0, 1);
    tx_stress = 0;
    sd_stress = 0;
    tick(60);

    // Reset after the third data byte, then a clean dump
    b0 = got_bytes.size();
    base_addr = AW'(32'h200);
    word_count = AW'(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t = 0;
    while (got_bytes.size() < b0 + 4 && t < 2000) begin
      tick(1);
      t++;
    end
    chk("rstmid_reached_3rd_byte", 32'(t < 2000), 32'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rstmid_active", 32'(active), 32'd0);
    inject_req++;
    tick(5);
    chk("rstmid_no_stale_bytes", 32'(got_bytes.size() - b0), 32'd4);
    chk("rstmid_still_idle", 32'(active), 32'd0);
    run_dump("after_rst", AW'(32'h300), AW'(1), 0, 0);

    chk("no_strobe_while_tx_busy", 32'(viol_tx), 32'd0);
    chk("no_request_while_busy", 32'(viol_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
